// File: rtl/regfile_write_buffer.sv
// -----------------------------------------------------------------------------
// regfile_write_buffer
//   Write-side initiator for the 32x32 register file. Write requests from
//   pipeline writeback are queued in a small FIFO and drained to the register
//   file's single write port at one per cycle through a registered output
//   stage (wb_en/wb_reg/wb_data). The register file captures on the negedge
//   that follows the posedge where wb_en is set.
//
//   Requests addressed to register 0 complete their handshake but are dropped,
//   so register 0 is never written through this block.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   : combinational lookup of pending data (FIFO + output stage),
//                 youngest matching entry wins.
//     undefined : lk_* inputs ignored, lk_hit*/lk_data* tied to zero.
//
// Ports
//   clk                   clock, all state updates on posedge
//   rst_n                 asynchronous active-low reset
//   in_valid/in_ready     request handshake (in_ready depends on state only)
//   in_reg/in_data        destination register / data of the request
//   wb_en/wb_reg/wb_data  registered register-file write port
//   count                 FIFO entries pending, excluding the output stage
//   lk_reg1/lk_reg2       bypass lookup addresses
//   lk_hit1/lk_hit2       a pending write to lk_regN exists
//   lk_data1/lk_data2     youngest pending data for lk_regN
// -----------------------------------------------------------------------------
module regfile_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_reg,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       wb_en,
    output logic [ADDR_W-1:0]          wb_reg,
    output logic [DATA_W-1:0]          wb_data,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [ADDR_W-1:0]          lk_reg1,
    input  logic [ADDR_W-1:0]          lk_reg2,
    output logic                       lk_hit1,
    output logic                       lk_hit2,
    output logic [DATA_W-1:0]          lk_data1,
    output logic [DATA_W-1:0]          lk_data2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] mem_reg_r  [DEPTH];
    logic [DATA_W-1:0] mem_data_r [DEPTH];
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [CW-1:0]     count_r;
    logic              wb_en_r;
    logic [ADDR_W-1:0] wb_reg_r;
    logic [DATA_W-1:0] wb_data_r;

    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;

    // Full is judged from the stored count only; a same-cycle pop never
    // opens the door for a push when the FIFO is full.
    assign in_ready_s = (count_r != CW'(DEPTH));
    // Register-0 requests are consumed by the handshake but never stored.
    assign push_s     = in_valid && in_ready_s && (in_reg != {ADDR_W{1'b0}});
    assign pop_s      = (count_r != {CW{1'b0}});

    // FIFO storage, pointers, occupancy and the registered write-port stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg_r[i]  <= {ADDR_W{1'b0}};
                mem_data_r[i] <= {DATA_W{1'b0}};
            end
            rd_ptr_r  <= {PW{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            wb_en_r   <= 1'b0;
            wb_reg_r  <= {ADDR_W{1'b0}};
            wb_data_r <= {DATA_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_reg_r[wr_ptr_r]  <= in_reg;
                mem_data_r[wr_ptr_r] <= in_data;
                wr_ptr_r             <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                wb_en_r   <= 1'b1;
                wb_reg_r  <= mem_reg_r[rd_ptr_r];
                wb_data_r <= mem_data_r[rd_ptr_r];
                rd_ptr_r  <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                // Address/data hold so the port stays quiet between writes.
                wb_en_r   <= 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign wb_en    = wb_en_r;
    assign wb_reg   = wb_reg_r;
    assign wb_data  = wb_data_r;
    assign count    = count_r;

`ifdef WB_BYPASS_EN
    logic [DATA_W:0] lk1_s;
    logic [DATA_W:0] lk2_s;

    // Returns {hit, data}. Entries are scanned oldest to youngest (output
    // stage, then head .. tail) so the last match is the youngest one.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] key);
        logic [DATA_W:0] res;
        logic [PW-1:0]   idx;
        res = {(DATA_W+1){1'b0}};
        if (key != {ADDR_W{1'b0}}) begin
            if (wb_en_r && (wb_reg_r == key)) begin
                res = {1'b1, wb_data_r};
            end else begin
                res = {(DATA_W+1){1'b0}};
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_r + PW'(i);
                if ((CW'(i) < count_r) && (mem_reg_r[idx] == key)) begin
                    res = {1'b1, mem_data_r[idx]};
                end else begin
                    res = res;
                end
            end
        end else begin
            res = {(DATA_W+1){1'b0}};
        end
        return res;
    endfunction

    // Bypass lookups for both read ports.
    always_comb begin
        lk1_s = lookup(lk_reg1);
        lk2_s = lookup(lk_reg2);
    end

    assign lk_hit1  = lk1_s[DATA_W];
    assign lk_data1 = lk1_s[DATA_W-1:0];
    assign lk_hit2  = lk2_s[DATA_W];
    assign lk_data2 = lk2_s[DATA_W-1:0];
`else
    logic unused_lk_s;
    assign unused_lk_s = ^{lk_reg1, lk_reg2};
    assign lk_hit1     = 1'b0;
    assign lk_hit2     = 1'b0;
    assign lk_data1    = {DATA_W{1'b0}};
    assign lk_data2    = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_write_buffer.sv
module tb_regfile_write_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CW     = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] lk_reg1, lk_reg2;
    logic              lk_hit1, lk_hit2;
    logic [DATA_W-1:0] lk_data1, lk_data2;

    int n_checks;
    int n_fail;

    regfile_write_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .count(count),
        .lk_reg1(lk_reg1), .lk_reg2(lk_reg2),
        .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
        .lk_data1(lk_data1), .lk_data2(lk_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached register file and a log of every write that reaches it.
    logic [DATA_W-1:0]        rf [32];
    logic [ADDR_W+DATA_W-1:0] wlog [$];
    always @(negedge clk) begin
        if (wb_en) begin
            rf[wb_reg] <= wb_data;
            wlog.push_back({wb_reg, wb_data});
        end
    end

    // Reference model: list of pending writes plus the write-port contents.
    logic [ADDR_W+DATA_W-1:0] q [$];
    logic                     m_en;
    logic [ADDR_W-1:0]        m_reg;
    logic [DATA_W-1:0]        m_data;

    function automatic logic [DATA_W:0] ref_lookup(input logic [ADDR_W-1:0] key);
        if (!BYP || key == '0) return '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i][ADDR_W+DATA_W-1:DATA_W] == key) return {1'b1, q[i][DATA_W-1:0]};
        if (m_en && m_reg == key) return {1'b1, m_data};
        return '0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_en = 1'b0; m_reg = '0; m_data = '0;
    endtask

    // One clock: the model advances by the same rules the buffer must obey.
    task automatic cycle();
        logic acc;
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
        logic [ADDR_W+DATA_W-1:0] e;
        acc = in_valid && (q.size() != DEPTH);
        r = in_reg; d = in_data;
        @(posedge clk); #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            m_en = 1'b1; m_reg = e[ADDR_W+DATA_W-1:DATA_W]; m_data = e[DATA_W-1:0];
        end else begin
            m_en = 1'b0;
        end
        if (acc && r != '0) q.push_back({r, d});
    endtask

    task automatic idle();
        in_valid = 1'b0; in_reg = '0; in_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); lk_reg1 = '0; lk_reg2 = '0;
        model_reset();
        #1;
        n_checks++;
        if (wb_en !== 1'b0 || wb_reg !== '0 || wb_data !== '0) begin
            n_fail++; $display("FAIL reset_wb: got en=%0b reg=%0d data=%h, want 0/0/0", wb_en, wb_reg, wb_data);
        end
        n_checks++;
        if (count !== '0 || in_ready !== 1'b1 || lk_hit1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got count=%0d ready=%0b hit=%0b, want 0/1/0", count, in_ready, lk_hit1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // Mid-stream reset.
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_reg = ADDR_W'(i); in_data = DATA_W'(i * 100);
            cycle();
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        wlog.delete();
        n_checks++;
        if (wb_en !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_midstream: got en=%0b count=%0d ready=%0b, want 0/0/1", wb_en, count, in_ready);
        end
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
        repeat (4) cycle();
        n_checks++;
        if (wlog.size() !== 0) begin
            n_fail++; $display("FAIL reset_no_writes: got %0d writes after release, want 0", wlog.size());
        end
    endtask

    task automatic test_single_write();
        idle();
        in_valid = 1'b1; in_reg = 5'd5; in_data = 32'hA5A5_0001;
        cycle();
        idle();
        n_checks++;
        if (wb_en !== 1'b0 || count !== CW'(1)) begin
            n_fail++; $display("FAIL single_n: got en=%0b count=%0d, want 0/1", wb_en, count);
        end
        cycle();
        n_checks++;
        if (wb_en !== 1'b1 || wb_reg !== 5'd5 || wb_data !== 32'hA5A5_0001) begin
            n_fail++; $display("FAIL single_n1: got en=%0b reg=%0d data=%h, want 1/5/a5a50001", wb_en, wb_reg, wb_data);
        end
        @(negedge clk); #1;
        n_checks++;
        if (rf[5] !== 32'hA5A5_0001) begin
            n_fail++; $display("FAIL single_rf: got rf[5]=%h, want a5a50001", rf[5]);
        end
        cycle();
        n_checks++;
        if (wb_en !== 1'b0 || wb_reg !== 5'd5 || wb_data !== 32'hA5A5_0001) begin
            n_fail++; $display("FAIL single_hold: got en=%0b reg=%0d data=%h, want 0/5/a5a50001", wb_en, wb_reg, wb_data);
        end
    endtask

    task automatic test_reg0();
        idle();
        cycle();
        in_valid = 1'b1; in_reg = 5'd0; in_data = 32'hFFFF_FFFF;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reg0_ready: got %0b, want 1", in_ready);
        end
        cycle();
        idle();
        n_checks++;
        if (count !== '0 || wb_en !== 1'b0) begin
            n_fail++; $display("FAIL reg0_count: got count=%0d en=%0b, want 0/0", count, wb_en);
        end
        cycle();
        n_checks++;
        if (wb_en !== 1'b0) begin
            n_fail++; $display("FAIL reg0_wben: got %0b, want 0", wb_en);
        end
    endtask

    task automatic test_fill();
        int waited;
        idle();
        wlog.delete();
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_reg = ADDR_W'(i); in_data = DATA_W'(i * 10);
            n_checks++;
            if (in_ready !== (count != CW'(DEPTH)) || count > CW'(DEPTH)) begin
                n_fail++; $display("FAIL fill_ready: got ready=%0b count=%0d", in_ready, count);
            end
            cycle();
            n_checks++;
            if (count !== CW'(q.size())) begin
                n_fail++; $display("FAIL fill_count: got %0d, want %0d", count, q.size());
            end
        end
        idle();
        waited = 0;
        while ((wb_en !== 1'b0 || count !== '0) && waited < 20) begin
            cycle(); waited++;
        end
        @(negedge clk); #1;
        n_checks++;
        if (waited >= 20) begin
            n_fail++; $display("FAIL fill_drain_timeout: got count=%0d en=%0b after 20 cycles, want drained", count, wb_en);
        end
        n_checks++;
        if (wlog.size() !== 5) begin
            n_fail++; $display("FAIL fill_nwrites: got %0d, want 5", wlog.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (wlog[i] !== {ADDR_W'(i + 1), DATA_W'((i + 1) * 10)}) begin
                    n_fail++; $display("FAIL fill_order[%0d]: got %h, want reg %0d data %0d", i, wlog[i], i + 1, (i + 1) * 10);
                end
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        lk_reg1 = 5'd7; lk_reg2 = 5'd0;
        in_valid = 1'b1; in_reg = 5'd7; in_data = 32'd1;
        cycle();
        n_checks++;
        if (lk_hit1 !== BYP || lk_data1 !== (BYP ? 32'd1 : 32'd0)) begin
            n_fail++; $display("FAIL byp_first: got hit=%0b data=%0d, want %0b/%0d", lk_hit1, lk_data1, BYP, BYP ? 1 : 0);
        end
        in_data = 32'd2;
        cycle();
        idle();
        n_checks++;
        if (lk_hit1 !== BYP || lk_data1 !== (BYP ? 32'd2 : 32'd0) || lk_hit2 !== 1'b0 || lk_data2 !== '0) begin
            n_fail++; $display("FAIL byp_young: got hit1=%0b data1=%0d hit2=%0b, want %0b/%0d/0", lk_hit1, lk_data1, lk_hit2, BYP, BYP ? 2 : 0);
        end
        cycle();
        n_checks++;
        if (lk_hit1 !== BYP || lk_data1 !== (BYP ? 32'd2 : 32'd0)) begin
            n_fail++; $display("FAIL byp_outstage: got hit=%0b data=%0d, want %0b/%0d", lk_hit1, lk_data1, BYP, BYP ? 2 : 0);
        end
        cycle();
        n_checks++;
        if (lk_hit1 !== 1'b0 || lk_data1 !== '0) begin
            n_fail++; $display("FAIL byp_drained: got hit=%0b data=%0d, want 0/0", lk_hit1, lk_data1);
        end
    endtask

    task automatic test_random();
        logic [DATA_W:0] e1, e2;
        for (int c = 0; c < 300; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_reg   = ADDR_W'($urandom_range(0, 7));
            in_data  = DATA_W'($urandom);
            lk_reg1  = ADDR_W'($urandom_range(0, 7));
            lk_reg2  = ADDR_W'($urandom_range(0, 7));
            #1;
            e1 = ref_lookup(lk_reg1);
            e2 = ref_lookup(lk_reg2);
            n_checks++;
            if (in_ready !== (q.size() != DEPTH) || count !== CW'(q.size())) begin
                n_fail++; $display("FAIL rnd_state c%0d: got ready=%0b count=%0d, want count %0d", c, in_ready, count, q.size());
            end
            n_checks++;
            if ({lk_hit1, lk_data1} !== e1 || {lk_hit2, lk_data2} !== e2) begin
                n_fail++; $display("FAIL rnd_lookup c%0d: got %0b/%h %0b/%h, want %h %h", c, lk_hit1, lk_data1, lk_hit2, lk_data2, e1, e2);
            end
            cycle();
            n_checks++;
            if (wb_en !== m_en || (m_en && (wb_reg !== m_reg || wb_data !== m_data))) begin
                n_fail++; $display("FAIL rnd_wb c%0d: got en=%0b reg=%0d data=%h, want %0b/%0d/%h", c, wb_en, wb_reg, wb_data, m_en, m_reg, m_data);
            end
        end
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_write();
        test_reg0();
        test_fill();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
